// File: rtl/pic_in_service.sv
// In-service register and highest-level resolver for an 8259A-style PIC.
// Define PIC_IS_ENCODED_LEVEL_EN to add highest_level_id/highest_level_valid.
module pic_in_service (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] priority_rotate,
    input  logic [7:0] interrupt_special_mask,
    input  logic [7:0] interrupt,
    input  logic       latch_in_service,
    input  logic [7:0] end_of_interrupt,
    output logic [7:0] in_service_register,
    output logic [7:0] highest_level_in_service
`ifdef PIC_IS_ENCODED_LEVEL_EN
    ,
    output logic [2:0] highest_level_id,
    output logic       highest_level_valid
`endif
);

    logic [7:0]  isr;
    logic [7:0]  isr_next;
    logic [7:0]  masked;
    logic [7:0]  rotated;
    logic [7:0]  lowest;
    logic [7:0]  level;
    logic [2:0]  shift;
    logic [15:0] wide_r;
    logic [15:0] wide_l;

    // Set takes precedence over a same-cycle clear of the same bit.
    assign isr_next = (isr & ~end_of_interrupt)
                    | (latch_in_service ? interrupt : 8'h00);

    // Rotate so bit 0 is the highest-priority IR, pick lowest set bit, undo.
    assign shift   = priority_rotate + 3'd1;
    assign masked  = isr & ~interrupt_special_mask;
    assign wide_r  = {masked, masked} >> shift;
    assign rotated = wide_r[7:0];
    assign lowest  = rotated & (~rotated + 8'd1);
    assign wide_l  = {lowest, lowest} << shift;
    assign level   = wide_l[15:8];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            isr                      <= 8'h00;
            highest_level_in_service <= 8'h00;
        end else begin
            isr                      <= isr_next;
            highest_level_in_service <= level;
        end
    end

    assign in_service_register = isr;

`ifdef PIC_IS_ENCODED_LEVEL_EN
    logic [2:0] level_id;

    always_comb begin
        level_id = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (level[i]) level_id = i[2:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            highest_level_id    <= 3'd0;
            highest_level_valid <= 1'b0;
        end else begin
            highest_level_id    <= level_id;
            highest_level_valid <= |level;
        end
    end
`endif

endmodule

// File: tb/tb_pic_in_service.sv
// Directed table plus randomized model-checked bench for pic_in_service.
// Optional encoded outputs are checked when PIC_IS_ENCODED_LEVEL_EN is defined.
module tb_pic_in_service;

    logic       clk;
    logic       rst_n;
    logic [2:0] priority_rotate;
    logic [7:0] interrupt_special_mask;
    logic [7:0] interrupt;
    logic       latch_in_service;
    logic [7:0] end_of_interrupt;
    logic [7:0] in_service_register;
    logic [7:0] highest_level_in_service;
`ifdef PIC_IS_ENCODED_LEVEL_EN
    logic [2:0] highest_level_id;
    logic       highest_level_valid;
`endif

    int checks = 0;
    int errors = 0;

    logic [7:0] m_isr;
    logic [7:0] m_hl;

    pic_in_service dut (
        .clk                      (clk),
        .rst_n                    (rst_n),
        .priority_rotate          (priority_rotate),
        .interrupt_special_mask   (interrupt_special_mask),
        .interrupt                (interrupt),
        .latch_in_service         (latch_in_service),
        .end_of_interrupt         (end_of_interrupt),
        .in_service_register      (in_service_register),
        .highest_level_in_service (highest_level_in_service)
`ifdef PIC_IS_ENCODED_LEVEL_EN
        ,
        .highest_level_id         (highest_level_id),
        .highest_level_valid      (highest_level_valid)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst_n;
        logic [2:0] rot;
        logic [7:0] mask;
        logic [7:0] intr;
        logic       latch;
        logic [7:0] eoi;
        logic [7:0] exp_isr;
        logic [7:0] exp_hl;
    } vec_t;

    vec_t vecs[$];

    // Walk IR levels from highest to lowest priority; first unmasked one wins.
    function automatic logic [7:0] ref_highest(input logic [7:0] isr,
                                               input logic [7:0] mask,
                                               input logic [2:0] rot);
        int lvl;
        for (int k = 0; k < 8; k++) begin
            lvl = (int'(rot) + 1 + k) % 8;
            if (isr[lvl] && !mask[lvl]) return 8'(1 << lvl);
        end
        return 8'h00;
    endfunction

    function automatic int ref_id(input logic [7:0] onehot);
        for (int i = 0; i < 8; i++) if (onehot[i]) return i;
        return 0;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic [2:0] rot,
                         input logic [7:0] mask, input logic [7:0] intr,
                         input logic lat, input logic [7:0] eoi);
        rst_n                  = r;
        priority_rotate        = rot;
        interrupt_special_mask = mask;
        interrupt              = intr;
        latch_in_service       = lat;
        end_of_interrupt       = eoi;
    endtask

    // One clock edge; the model advances with the same sampled inputs.
    task automatic step();
        logic [7:0] hl_n;
        logic [7:0] isr_n;
        @(posedge clk);
        if (!rst_n) begin
            hl_n  = 8'h00;
            isr_n = 8'h00;
        end else begin
            hl_n  = ref_highest(m_isr, interrupt_special_mask, priority_rotate);
            isr_n = m_isr;
            for (int i = 0; i < 8; i++) begin
                if (end_of_interrupt[i]) isr_n[i] = 1'b0;
                if (latch_in_service && interrupt[i]) isr_n[i] = 1'b1;
            end
        end
        m_isr = isr_n;
        m_hl  = hl_n;
        #1;
    endtask

    task automatic check_enc(input logic [7:0] hl);
`ifdef PIC_IS_ENCODED_LEVEL_EN
        check("level_id", int'(highest_level_id), ref_id(hl));
        check("level_valid", int'(highest_level_valid), int'(hl != 8'h00));
`else
        if (hl === 8'hxx) check("hl_known", int'(hl), 0);
`endif
    endtask

    function automatic vec_t mk(input logic r, input logic [2:0] rot,
                                input logic [7:0] mask, input logic [7:0] intr,
                                input logic lat, input logic [7:0] eoi,
                                input logic [7:0] ei, input logic [7:0] eh);
        vec_t v;
        v.rst_n = r; v.rot = rot; v.mask = mask; v.intr = intr;
        v.latch = lat; v.eoi = eoi; v.exp_isr = ei; v.exp_hl = eh;
        return v;
    endfunction

    initial begin
        m_isr = 8'h00;
        m_hl  = 8'h00;
        drive(1'b0, 3'd7, 8'h00, 8'hFF, 1'b1, 8'h00);

        // reset held with latch active
        vecs.push_back(mk(0, 7, 8'h00, 8'hFF, 1, 8'h00, 8'h00, 8'h00));
        vecs.push_back(mk(0, 7, 8'h00, 8'hFF, 1, 8'h00, 8'h00, 8'h00));
        // latch with concurrent EOI
        vecs.push_back(mk(1, 1, 8'hC0, 8'h33, 1, 8'h01, 8'h33, 8'h00));
        vecs.push_back(mk(1, 1, 8'hC0, 8'h33, 0, 8'h01, 8'h32, 8'h10));
        vecs.push_back(mk(1, 1, 8'hC0, 8'h00, 0, 8'h00, 8'h32, 8'h10));
        vecs.push_back(mk(1, 1, 8'hC0, 8'h00, 0, 8'hFF, 8'h00, 8'h10));
        // fixed priority
        vecs.push_back(mk(1, 7, 8'h00, 8'h84, 1, 8'h00, 8'h84, 8'h00));
        vecs.push_back(mk(1, 7, 8'h00, 8'h00, 0, 8'h00, 8'h84, 8'h04));
        vecs.push_back(mk(1, 7, 8'h00, 8'h00, 0, 8'h04, 8'h80, 8'h04));
        vecs.push_back(mk(1, 7, 8'h00, 8'h00, 0, 8'h00, 8'h80, 8'h80));
        // rotation wrap
        vecs.push_back(mk(1, 3, 8'h00, 8'h09, 1, 8'hFF, 8'h09, 8'h80));
        vecs.push_back(mk(1, 3, 8'h00, 8'h00, 0, 8'h00, 8'h09, 8'h01));
        // special mask
        vecs.push_back(mk(1, 7, 8'h02, 8'h06, 1, 8'hFF, 8'h06, 8'h01));
        vecs.push_back(mk(1, 7, 8'h02, 8'h00, 0, 8'h00, 8'h06, 8'h04));
        vecs.push_back(mk(1, 7, 8'h06, 8'h00, 0, 8'h00, 8'h06, 8'h00));
        // set/clear collision
        vecs.push_back(mk(1, 7, 8'h00, 8'h00, 0, 8'hFF, 8'h00, 8'h02));
        vecs.push_back(mk(1, 7, 8'h00, 8'h08, 1, 8'h08, 8'h08, 8'h00));
        vecs.push_back(mk(1, 7, 8'h00, 8'h00, 0, 8'h00, 8'h08, 8'h08));
        // mid-operation reset, then first post-reset value
        vecs.push_back(mk(1, 7, 8'h00, 8'h0F, 1, 8'h00, 8'h0F, 8'h08));
        vecs.push_back(mk(0, 7, 8'h00, 8'h0F, 1, 8'h00, 8'h00, 8'h00));
        vecs.push_back(mk(1, 7, 8'h00, 8'h00, 0, 8'h00, 8'h00, 8'h00));

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst_n, vecs[i].rot, vecs[i].mask,
                  vecs[i].intr, vecs[i].latch, vecs[i].eoi);
            step();
            check($sformatf("vec%0d_isr", i),
                  int'(in_service_register), int'(vecs[i].exp_isr));
            check($sformatf("vec%0d_hl", i),
                  int'(highest_level_in_service), int'(vecs[i].exp_hl));
            check_enc(vecs[i].exp_hl);
        end

        for (int n = 0; n < 400; n++) begin
            logic [7:0] intr;
            logic [7:0] eoi;
            logic [7:0] mask;
            intr = ($urandom_range(0, 4) == 0) ? 8'($urandom)
                                               : 8'(1 << $urandom_range(0, 7));
            case ($urandom_range(0, 3))
                0:       eoi = 8'(1 << $urandom_range(0, 7));
                1:       eoi = 8'($urandom);
                default: eoi = 8'h00;
            endcase
            mask = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
            drive(($urandom_range(0, 49) != 0), 3'($urandom_range(0, 7)),
                  mask, intr, 1'($urandom), eoi);
            step();
            check("rand_isr", int'(in_service_register), int'(m_isr));
            check("rand_hl", int'(highest_level_in_service), int'(m_hl));
            check_enc(m_hl);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pic_in_service.md
Name: pic_in_service

Overview:
- In-Service Register (ISR) block of the 8259A-compatible programmable interrupt controller.
- Latches the interrupt being acknowledged into the ISR and clears bits on end-of-interrupt (EOI).
- Reports the highest-priority level currently in service, as a one-hot vector, under rotating priority and special mask.
- Sits between the priority resolver / interrupt-acknowledge control and the EOI/OCW2 command decoder.

Parameters:
- None. Fixed width of 8 IR levels.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  reset; synchronous, active-low.
- priority_rotate  input  3  lowest-priority IR number; the highest priority is IR((priority_rotate+1) mod 8). Value 7 gives fixed priority with IR0 highest.
- interrupt_special_mask  input  8  special-mask-mode bits; a set bit excludes that IR from the highest-level computation.
- interrupt  input  8  one-hot (normally) IR being acknowledged.
- latch_in_service  input  1  when high, ORs `interrupt` into the ISR.
- end_of_interrupt  input  8  bit mask of ISR bits to clear (specific or non-specific EOI already decoded upstream).
- in_service_register  output  8  current ISR contents.
- highest_level_in_service  output  8  one-hot highest-priority unmasked in-service level; 0 if none.

Behaviour:
- Reset: when rst_n=0 at a rising edge, in_service_register=8'h00 and highest_level_in_service=8'h00. Reset overrides all other inputs.
- ISR update, every edge when not in reset:
  - isr_next = (isr & ~end_of_interrupt) | (latch_in_service ? interrupt : 8'h00).
  - If the same bit is set and cleared in one cycle, the set wins.
- A multi-bit `interrupt` is latched as given; there is no one-hot checking.
- EOI bits for levels not in service have no effect. end_of_interrupt may be held; it clears every cycle it is asserted.
- Highest-level computation, combinational from the current registered ISR:
  - m = isr & ~interrupt_special_mask.
  - r = m rotated right by (priority_rotate+1) mod 8, so that bit 0 of r is the highest-priority IR.
  - Isolate the lowest set bit of r.
  - Rotate left by the same amount, giving a one-hot result in IR numbering.
- The highest-level result is registered into highest_level_in_service. It therefore lags in_service_register by one clock: 2 cycles after a latch edge overall.
- All inputs are sampled only at the clock edge. No combinational input-to-output paths.
- Reset asserted mid-operation clears both outputs on that edge. The first post-reset highest_level value is 0.

Optional Feature:
- Macro: PIC_IS_ENCODED_LEVEL_EN.
- When defined, adds two outputs:
  - highest_level_id (3 bits): binary IR number of highest_level_in_service.
  - highest_level_valid (1 bit): high when highest_level_in_service != 0.
- Both are registered in the same cycle as highest_level_in_service, and both reset to 0.
- When not defined, these ports and their logic do not exist; all other behaviour is identical.

Test Plan:
- Reset: hold rst_n=0 for 2 edges with interrupt=8'hFF and latch=1 -> both outputs 8'h00.
- Latch with concurrent EOI:
  - Stimulus: priority_rotate=1, special_mask=8'hC0, interrupt=8'h33, end_of_interrupt=8'h01; latch=1 for one cycle, then 0.
  - Response: ISR=8'h33 after the latch edge, then 8'h32 on the next edge. highest_level settles to 8'h10 (IR4 beats IR5 and IR1 when IR2 is highest priority).
- Fixed priority: rotate=7, mask=0, ISR loaded to 8'h84 -> highest_level=8'h04; EOI 8'h04 -> ISR=8'h80, highest_level=8'h80 one cycle later.
- Rotation wrap: rotate=3, ISR=8'h09 (IR0, IR3) -> highest_level=8'h01, since IR3 is lowest priority.
- Special mask: rotate=7, ISR=8'h06, mask=8'h02 -> highest_level=8'h04; mask=8'h06 -> 8'h00.
- Set/clear collision: ISR=8'h00, latch=1 with interrupt=8'h08 and end_of_interrupt=8'h08 in the same cycle -> ISR=8'h08. With the macro defined, highest_level_id=3 and highest_level_valid=1.
